branch_resolve_ctrl: RTL and testbench
======================================

BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, legal 1..7: number of cycles flush is held after a mispredict.
REQ-002 SHALL have parameter BHT_IDX_W, default 4: BHT index width (2^BHT_IDX_W entries).
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX-stage instruction valid
- ex_stall  in  1  EX held this cycle, no resolution
- ex_is_branch  in  1  EX instruction is a conditional branch
- ex_b_control  in  3  branch condition (funct3 encoding)
- ex_r1, ex_r2  in  32 each  source operands
- ex_pc  in  32  branch PC
- ex_target  in  32  taken target
- ex_pred_taken  in  1  prediction carried with the instruction
- if_pc  in  32  fetch PC for prediction lookup
- if_pred_taken  out  1  prediction for if_pc
- redirect_valid  out  1  one-cycle PC redirect strobe
- redirect_pc  out  32  corrected PC
- flush  out  1  squash IF/ID/EX wrong-path instructions
- branch_cnt, mispredict_cnt  out  32 each  performance counters

Function
REQ-004 Resolve event SHALL be ex_valid & !ex_stall & ex_is_branch & (state == IDLE).
REQ-005 Actual outcome SHALL be: 000 r1==r2; 001 r1!=r2; 100 signed r1<r2; 101 signed r1>=r2; 110 unsigned r1<r2; 111 unsigned r1>=r2; 010/011 not taken.
REQ-006 Mispredict SHALL be resolve event with actual != ex_pred_taken.
REQ-007 Corrected PC SHALL be ex_target if actual taken, else ex_pc+4 (mod 2^32).
REQ-008 FSM SHALL have states IDLE and FLUSH; IDLE->FLUSH on mispredict; FLUSH->IDLE after FLUSH_CYCLES cycles in FLUSH.
REQ-009 redirect_valid and redirect_pc SHALL be registered: asserted for exactly the one cycle following the mispredict edge.
REQ-010 flush SHALL be high for exactly FLUSH_CYCLES consecutive cycles, first cycle coincident with redirect_valid.
REQ-011 In FLUSH, EX inputs SHALL be ignored: no redirect, no BHT update, no counter increment.
REQ-012 redirect_pc SHALL hold its last value when redirect_valid is low.
REQ-013 branch_cnt SHALL increment on every resolve event; mispredict_cnt on every mispredict; both wrap 0xFFFFFFFF->0.
REQ-014 ex_stall high SHALL suppress resolution; the held branch resolves once, in the first unstalled cycle.
REQ-015 Correct prediction SHALL produce no redirect and no flush.

Reset
REQ-016 rst_n low SHALL asynchronously force state IDLE, redirect_valid 0, redirect_pc 0, flush 0, branch_cnt 0, mispredict_cnt 0, all BHT entries 2'b01.
REQ-017 Reset asserted mid-FLUSH SHALL abort the flush; after release the block is IDLE with flush 0.
REQ-018 First resolve event SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-019 Macro BHT_EN SHALL select dynamic prediction.
REQ-020 With BHT_EN defined: 2^BHT_IDX_W 2-bit saturating counters indexed by PC[BHT_IDX_W+1:2]; if_pred_taken = counter[if_pc index] bit 1 (combinational); on resolve event counter at ex_pc index increments (taken, saturates 11) or decrements (not taken, saturates 00).
REQ-021 With BHT_EN defined, same-cycle lookup and update of one index SHALL return the pre-update value.
REQ-022 Without BHT_EN: no table; if_pred_taken tied 0 (static not-taken); all other behaviour unchanged.

Verification
REQ-023 BEQ r1=r2=5, pred 0, pc 0x100, target 0x180 -> next cycle redirect_valid 1, redirect_pc 0x180; flush high 2 cycles; mispredict_cnt 1.
REQ-024 BLT r1=0xFFFFFFFF, r2=1, pred 1 -> no redirect, no flush; BLTU same operands, pred 1, pc 0x200 -> redirect_pc 0x204.
REQ-025 Mispredict, then mispredicting branch presented on both flush cycles -> single redirect; branch_cnt 1, mispredict_cnt 1.
REQ-026 BHT_EN: 3 taken resolves at pc 0x40 -> if_pc 0x40 counter 01->10->11->11, if_pred_taken 1 after first; if_pc 0x80 (same index, W=4) aliases and also predicts taken.
REQ-027 rst_n pulsed low during first flush cycle -> flush 0 immediately, counters 0, BHT entries 01, branch accepted on first edge after release.
REQ-028 ex_stall high 3 cycles with mispredicting BNE -> no redirect while stalled; exactly one redirect after stall drops.

Source files
------------

// File: rtl/branch_resolve_if.sv
// Branch resolution bus between the EX/IF pipeline stages and branch_resolve_ctrl.
// The master drives the EX operands and fetch PC; the slave returns prediction, redirect, flush and counters.
interface branch_resolve_if;
    logic        ex_valid;
    logic        ex_stall;
    logic        ex_is_branch;
    logic [2:0]  ex_b_control;
    logic [31:0] ex_r1;
    logic [31:0] ex_r2;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    modport master (
        output ex_valid, ex_stall, ex_is_branch, ex_b_control, ex_r1, ex_r2,
               ex_pc, ex_target, ex_pred_taken, if_pc,
        input  if_pred_taken, redirect_valid, redirect_pc, flush,
               branch_cnt, mispredict_cnt
    );

    modport slave (
        input  ex_valid, ex_stall, ex_is_branch, ex_b_control, ex_r1, ex_r2,
               ex_pc, ex_target, ex_pred_taken, if_pc,
        output if_pred_taken, redirect_valid, redirect_pc, flush,
               branch_cnt, mispredict_cnt
    );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Resolves EX-stage conditional branches, issues a one-cycle PC redirect and a multi-cycle flush on mispredict.
// Define BHT_EN for a 2-bit saturating-counter branch history table; otherwise prediction is static not-taken.
module branch_resolve_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int BHT_IDX_W    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    branch_resolve_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_flush_cnt;
    logic [2:0]  w_flush_cnt_nxt;
    logic        r_redirect_valid;
    logic [31:0] r_redirect_pc;
    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispredict_cnt;

    logic        w_resolve;
    logic        w_taken;
    logic        w_mispredict;
    logic [31:0] w_correct_pc;

    assign w_resolve = bus.ex_valid & ~bus.ex_stall & bus.ex_is_branch & (r_state == IDLE);

    // NOTE: every variable written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_taken = 1'b0;
        case (bus.ex_b_control)
            3'b000:  w_taken = (bus.ex_r1 == bus.ex_r2);
            3'b001:  w_taken = (bus.ex_r1 != bus.ex_r2);
            3'b100:  w_taken = ($signed(bus.ex_r1) <  $signed(bus.ex_r2));
            3'b101:  w_taken = ($signed(bus.ex_r1) >= $signed(bus.ex_r2));
            3'b110:  w_taken = (bus.ex_r1 <  bus.ex_r2);
            3'b111:  w_taken = (bus.ex_r1 >= bus.ex_r2);
            default: w_taken = 1'b0;
        endcase
    end

    assign w_mispredict = w_resolve & (w_taken != bus.ex_pred_taken);
    assign w_correct_pc = w_taken ? bus.ex_target : bus.ex_pc + 32'd4;

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        case (r_state)
            IDLE: begin
                if (w_mispredict) begin
                    w_state_nxt     = FLUSH;
                    w_flush_cnt_nxt = FLUSH_LAST;
                end
            end
            FLUSH: begin
                // Counter holds the number of flush cycles still to follow this one.
                if (r_flush_cnt == 3'd0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - 3'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_flush_cnt <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'd0;
            r_branch_cnt     <= 32'd0;
            r_mispredict_cnt <= 32'd0;
        end else begin
            r_redirect_valid <= w_mispredict;
            if (w_mispredict) begin
                r_redirect_pc <= w_correct_pc;
            end
            if (w_resolve) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (w_mispredict) begin
                r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
            end
        end
    end

    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.flush          = (r_state == FLUSH);
    assign bus.branch_cnt     = r_branch_cnt;
    assign bus.mispredict_cnt = r_mispredict_cnt;

`ifdef BHT_EN
    localparam int BHT_SIZE = 1 << BHT_IDX_W;

    logic [1:0]           r_bht [BHT_SIZE];
    logic [BHT_IDX_W-1:0] w_if_idx;
    logic [BHT_IDX_W-1:0] w_ex_idx;
    logic                 w_unused_bht;

    assign w_if_idx     = bus.if_pc[BHT_IDX_W+1:2];
    assign w_ex_idx     = bus.ex_pc[BHT_IDX_W+1:2];
    assign w_unused_bht = ^{bus.if_pc[31:BHT_IDX_W+2], bus.if_pc[1:0]};

    // NOTE: the table is reset entry by entry because every counter must come up weakly not-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_SIZE; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_resolve) begin
            if (w_taken && (r_bht[w_ex_idx] != 2'b11)) begin
                r_bht[w_ex_idx] <= r_bht[w_ex_idx] + 2'd1;
            end else if (!w_taken && (r_bht[w_ex_idx] != 2'b00)) begin
                r_bht[w_ex_idx] <= r_bht[w_ex_idx] - 2'd1;
            end
        end
    end

    // Lookup reads the registered table, so a same-cycle update is not visible yet.
    assign bus.if_pred_taken = r_bht[w_if_idx][1];
`else
    logic w_unused_bht;

    assign w_unused_bht      = (^bus.if_pc) ^ (BHT_IDX_W > 0);
    assign bus.if_pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl: directed scenarios plus randomized branches against a reference model.
module tb_branch_resolve_ctrl;

    localparam int FC    = 2;
    localparam int IDX_W = 4;
    localparam int BHT_N = 1 << IDX_W;

    typedef struct {
        logic        valid;
        logic        stall;
        logic        is_branch;
        logic [2:0]  ctl;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        pred;
        logic [31:0] if_pc;
    } txn_t;

    typedef struct {
        logic        redirect;
        logic [31:0] rpc;
        logic        flush;
        logic [31:0] bcnt;
        logic [31:0] mcnt;
        logic        pred;
    } snap_t;

    logic clk;
    logic rst_n;

    branch_resolve_if bif ();

    branch_resolve_ctrl #(.FLUSH_CYCLES(FC), .BHT_IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    snap_t       snap_q[$];
    logic [31:0] exp_redir_q[$];

    // Reference model state
    int          m_flush_left;
    logic        m_redir;
    logic [31:0] m_rpc;
    logic [31:0] m_bcnt;
    logic [31:0] m_mcnt;
    int          m_bht [BHT_N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit taken_of(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b);
        case (ctl)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) <  $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a <  b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % BHT_N);
    endfunction

    function automatic logic model_pred(input logic [31:0] pc);
`ifdef BHT_EN
        return m_bht[idx_of(pc)] >= 2;
`else
        return (pc != pc);
`endif
    endfunction

    task automatic model_reset();
        m_flush_left = 0;
        m_redir      = 1'b0;
        m_rpc        = 32'd0;
        m_bcnt       = 32'd0;
        m_mcnt       = 32'd0;
        for (int i = 0; i < BHT_N; i++) m_bht[i] = 1;
    endtask

    task automatic model_edge(input txn_t t);
        bit res;
        bit tk;
        bit mis;
        res = t.valid && !t.stall && t.is_branch && (m_flush_left == 0);
        tk  = taken_of(t.ctl, t.r1, t.r2);
        mis = res && (tk != t.pred);
        if (m_flush_left > 0) m_flush_left--;
        else if (mis)         m_flush_left = FC;
        m_redir = mis;
        if (mis) begin
            m_rpc = tk ? t.tgt : t.pc + 32'd4;
            exp_redir_q.push_back(m_rpc);
        end
        if (res) m_bcnt++;
        if (mis) m_mcnt++;
`ifdef BHT_EN
        if (res) begin
            if (tk) m_bht[idx_of(t.pc)] = (m_bht[idx_of(t.pc)] == 3) ? 3 : m_bht[idx_of(t.pc)] + 1;
            else    m_bht[idx_of(t.pc)] = (m_bht[idx_of(t.pc)] == 0) ? 0 : m_bht[idx_of(t.pc)] - 1;
        end
`endif
    endtask

    task automatic push_snap(input logic [31:0] if_pc);
        snap_t s;
        s.redirect = m_redir;
        s.rpc      = m_rpc;
        s.flush    = (m_flush_left > 0);
        s.bcnt     = m_bcnt;
        s.mcnt     = m_mcnt;
        s.pred     = model_pred(if_pc);
        snap_q.push_back(s);
    endtask

    task automatic drive(input txn_t t);
        bif.ex_valid      = t.valid;
        bif.ex_stall      = t.stall;
        bif.ex_is_branch  = t.is_branch;
        bif.ex_b_control  = t.ctl;
        bif.ex_r1         = t.r1;
        bif.ex_r2         = t.r2;
        bif.ex_pc         = t.pc;
        bif.ex_target     = t.tgt;
        bif.ex_pred_taken = t.pred;
        bif.if_pc         = t.if_pc;
    endtask

    // Called just after a falling edge: inputs are held through the next rising edge and falling edge.
    task automatic apply(input txn_t t);
        drive(t);
        model_edge(t);
        push_snap(t.if_pc);
        @(negedge clk);
        #1;
    endtask

    function automatic txn_t br(input logic [2:0] ctl, input logic [31:0] r1, input logic [31:0] r2,
                                input logic [31:0] pc, input logic [31:0] tgt, input logic pred,
                                input logic stall);
        txn_t t;
        t.valid = 1'b1; t.stall = stall; t.is_branch = 1'b1; t.ctl = ctl;
        t.r1 = r1; t.r2 = r2; t.pc = pc; t.tgt = tgt; t.pred = pred; t.if_pc = pc;
        return t;
    endfunction

    function automatic txn_t idle(input logic [31:0] if_pc);
        txn_t t;
        t = br(3'd0, 32'd0, 32'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        t.valid = 1'b0;
        t.if_pc = if_pc;
        return t;
    endfunction

    task automatic reset_pulse(input logic [31:0] if_pc);
        txn_t t;
        t = idle(if_pc);
        drive(t);
        #1 rst_n = 1'b0;
        #1;
        check("rst_flush",          32'(bif.flush),          32'd0);
        check("rst_redirect_valid", 32'(bif.redirect_valid), 32'd0);
        check("rst_redirect_pc",    bif.redirect_pc,          32'd0);
        check("rst_branch_cnt",     bif.branch_cnt,           32'd0);
        check("rst_mispredict_cnt", bif.mispredict_cnt,       32'd0);
        check("rst_if_pred",        32'(bif.if_pred_taken),   32'd0);
        #1 rst_n = 1'b1;
        model_reset();
        model_edge(t);
        push_snap(t.if_pc);
        @(negedge clk);
        #1;
    endtask

    // Monitor: compares every cycle's outputs and matches each redirect strobe against the expected-redirect queue.
    always @(negedge clk) begin
        snap_t       s;
        logic [31:0] e;
        if (snap_q.size() > 0) begin
            s = snap_q.pop_front();
            check("flush",          32'(bif.flush),          32'(s.flush));
            check("redirect_valid", 32'(bif.redirect_valid), 32'(s.redirect));
            check("redirect_pc",    bif.redirect_pc,          s.rpc);
            check("branch_cnt",     bif.branch_cnt,           s.bcnt);
            check("mispredict_cnt", bif.mispredict_cnt,       s.mcnt);
            check("if_pred_taken",  32'(bif.if_pred_taken),   32'(s.pred));
            if (bif.redirect_valid) begin
                if (exp_redir_q.size() > 0) begin
                    e = exp_redir_q.pop_front();
                    check("redirect_pc_q", bif.redirect_pc, e);
                end else begin
                    check("redirect_unexpected", 32'(bif.redirect_valid), 32'd0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'd5;
            3: return 32'h7FFF_FFFF;
            4: return 32'h8000_0000;
            5: return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [31:0] rand_pc();
        case ($urandom_range(0, 4))
            0: return 32'h40;
            1: return 32'h80;
            2: return 32'h100;
            3: return 32'h1C4;
            default: return {$urandom_range(0, 1023), 2'b00};
        endcase
    endfunction

    initial begin
        txn_t t;
        rst_n = 1'b0;
        model_reset();
        t = idle(32'h40);
        drive(t);
        push_snap(t.if_pc);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // BEQ taken, predicted not-taken: redirect to target, two flush cycles
        apply(br(3'b000, 32'd5, 32'd5, 32'h100, 32'h180, 1'b0, 1'b0));
        repeat (3) apply(idle(32'h0));

        // BLT signed taken and predicted taken; BLTU same operands not taken
        apply(br(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h380, 1'b1, 1'b0));
        apply(idle(32'h0));
        apply(br(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h280, 1'b1, 1'b0));
        repeat (3) apply(idle(32'h0));

        // Mispredicting branches presented during both flush cycles are ignored
        reset_pulse(32'h0);
        apply(br(3'b001, 32'd1, 32'd2, 32'h500, 32'h540, 1'b0, 1'b0));
        apply(br(3'b001, 32'd3, 32'd4, 32'h504, 32'h600, 1'b0, 1'b0));
        apply(br(3'b000, 32'd3, 32'd3, 32'h508, 32'h700, 1'b0, 1'b0));
        repeat (2) apply(idle(32'h0));

        // Train pc 0x40 taken three times, then look up the aliasing pc 0x80
        repeat (3) apply(br(3'b000, 32'd7, 32'd7, 32'h40, 32'h90, 1'b1, 1'b0));
        apply(idle(32'h80));
        apply(idle(32'h40));

        // Reset during the first flush cycle, then a branch on the first edge after release
        apply(br(3'b000, 32'd1, 32'd2, 32'h100, 32'h180, 1'b1, 1'b0));
        reset_pulse(32'h40);
        apply(br(3'b101, 32'd9, 32'd3, 32'h44, 32'h400, 1'b0, 1'b0));
        repeat (3) apply(idle(32'h44));

        // BNE mispredict held by a three-cycle stall resolves once
        repeat (3) apply(br(3'b001, 32'd1, 32'd2, 32'h600, 32'h640, 1'b0, 1'b1));
        apply(br(3'b001, 32'd1, 32'd2, 32'h600, 32'h640, 1'b0, 1'b0));
        repeat (3) apply(idle(32'h600));

        for (int i = 0; i < 400; i++) begin
            t.valid     = ($urandom_range(0, 99) < 85);
            t.stall     = ($urandom_range(0, 99) < 20);
            t.is_branch = ($urandom_range(0, 99) < 80);
            t.ctl       = 3'($urandom_range(0, 7));
            t.r1        = rand_op();
            t.r2        = ($urandom_range(0, 3) == 0) ? t.r1 : rand_op();
            t.pc        = rand_pc();
            t.tgt       = {$urandom_range(0, 4095), 2'b00};
            t.if_pc     = ($urandom_range(0, 1) == 1) ? t.pc : rand_pc();
            t.pred      = ($urandom_range(0, 1) == 1) ? model_pred(t.pc) : 1'($urandom_range(0, 1));
            apply(t);
        end

        repeat (4) apply(idle(32'h0));
        check("redirect_queue_drained", 32'(exp_redir_q.size()), 32'd0);
        check("snapshot_queue_drained", 32'(snap_q.size()),      32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
